// File: rtl/mips_issue_pkg.sv
// Shared decode constants, FSM state and hazard-history types for the issue sequencer.
package mips_issue_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 26;
  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;
  localparam int unsigned RD_HI = 15;
  localparam int unsigned RD_LO = 11;

  typedef enum logic [1:0] {IDLE, ISSUE, BUBBLE, FINISH} seq_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } hist_t;

  // Register written by an instruction; stores write none
  function automatic logic [4:0] dest_of(input logic [31:0] w);
    logic [5:0] op;
    op = w[OP_HI:OP_LO];
    if (op == OP_RTYPE)  return w[RD_HI:RD_LO];
    else if (op == OP_SW) return 5'd0;
    else                  return w[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational bubble-count calculation against the recent issue-slot history.
// Only instantiated when HAZARD_CHECK_EN is defined.
module issue_hazard_check
  import mips_issue_pkg::*;
#(
  parameter int unsigned LW_GAP  = 2,
  parameter int unsigned ALU_GAP = 0,
  parameter int unsigned HD      = 2,
  parameter int unsigned CW      = 2
) (
  input  logic [5:0]         op,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  hist_t [HD-1:0]     hist,
  output logic [CW-1:0]      need
);

  logic rt_src;

  assign rt_src = (op == OP_RTYPE) || (op == OP_SW);

  // Slot i has i issue slots between it and the candidate
  always_comb begin
    need = '0;
    for (int unsigned i = 0; i < HD; i++) begin
      automatic int unsigned gap = hist[i].is_load ? LW_GAP : ALU_GAP;
      if (hist[i].valid &&
          ((hist[i].dest == rs) || (rt_src && (hist[i].dest == rt))) &&
          (i < gap) && (CW'(gap - i) > need))
        need = CW'(gap - i);
    end
  end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Loadable program store that issues one instruction per cycle with load-use bubbles.
// HAZARD_CHECK_EN: bubble only on true register dependencies; otherwise LW_GAP after every load.
module instr_issue_sequencer
  import mips_issue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int IW      = 32,
  parameter int LW_GAP  = 2,
  parameter int ALU_GAP = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Re,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [IW-1:0] WrData,
  input  logic          Start,
  input  logic [AW:0]   Length,
  input  logic          Stall,
  output logic [IW-1:0] Opcode,
  output logic          OpValid,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Done
);

  localparam int unsigned GMAX = (LW_GAP > ALU_GAP) ? LW_GAP : ALU_GAP;
  localparam int unsigned HD   = (GMAX == 0) ? 1 : GMAX;
  localparam int unsigned CW   = $clog2(HD + 1);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [IW-1:0] mem [DEPTH];

  seq_state_t    state_r, state_n;
  logic [AW-1:0] pc_r, pc_n, pc_inc;
  logic [IW-1:0] op_r, op_n;
  logic          opv_r, opv_n;
  logic          busy_r, busy_n;
  logic          done_r, done_n;
  logic [CW-1:0] cnt_r, cnt_n, bub_cnt;
  logic [AW:0]   rem_r, rem_n, len_c;
  logic [IW-1:0] cur;
  logic          is_load, hold_slot, post_load;

  always_ff @(posedge Clk) begin
    if (WrEn && !busy_r)
      mem[WrAddr] <= WrData;
  end

  assign cur     = mem[pc_r];
  assign is_load = (cur[OP_HI:OP_LO] == OP_LW);
  assign pc_inc  = (pc_r == LAST_IDX) ? '0 : pc_r + AW'(1);
  assign len_c   = (Length > LEN_MAX) ? LEN_MAX : Length;

`ifdef HAZARD_CHECK_EN
  hist_t [HD-1:0] hist_r, hist_n;
  hist_t          slot;
  logic [CW-1:0]  need;

  issue_hazard_check #(
    .LW_GAP  (LW_GAP),
    .ALU_GAP (ALU_GAP),
    .HD      (HD),
    .CW      (CW)
  ) u_hazard (
    .op   (cur[OP_HI:OP_LO]),
    .rs   (cur[RS_HI:RS_LO]),
    .rt   (cur[RT_HI:RT_LO]),
    .hist (hist_r),
    .need (need)
  );

  // The detecting ISSUE cycle emits the first bubble itself
  assign hold_slot = (need != '0);
  assign bub_cnt   = need - CW'(1);
  assign post_load = 1'b0;

  always_comb begin
    slot = '0;
    if (state_r == ISSUE && !hold_slot) begin
      slot.dest    = dest_of(cur[31:0]);
      slot.valid   = (slot.dest != 5'd0);
      slot.is_load = is_load;
    end
  end

  always_comb begin
    hist_n = hist_r;
    if (!Stall) begin
      if (state_r == IDLE && Start)
        hist_n = '0;
      else if (state_r == ISSUE || state_r == BUBBLE) begin
        for (int unsigned i = HD - 1; i > 0; i--)
          hist_n[i] = hist_r[i-1];
        hist_n[0] = slot;
      end
    end
  end

  always_ff @(posedge Clk or posedge Re) begin
    if (Re) hist_r <= '0;
    else    hist_r <= hist_n;
  end
`else
  assign hold_slot = 1'b0;
  assign bub_cnt   = CW'(LW_GAP);
  assign post_load = is_load && (LW_GAP != 0);
`endif

  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    op_n    = op_r;
    opv_n   = opv_r;
    busy_n  = busy_r;
    done_n  = done_r;
    cnt_n   = cnt_r;
    rem_n   = rem_r;
    if (!Stall) begin
      done_n = 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            pc_n  = '0;
            rem_n = len_c;
            cnt_n = '0;
            if (len_c != '0) begin
              state_n = ISSUE;
              busy_n  = 1'b1;
            end else begin
              state_n = FINISH;
            end
          end
        end
        ISSUE: begin
          if (hold_slot) begin
            op_n    = '0;
            opv_n   = 1'b0;
            cnt_n   = bub_cnt;
            state_n = (bub_cnt == '0) ? ISSUE : BUBBLE;
          end else begin
            op_n  = cur;
            opv_n = 1'b1;
            pc_n  = pc_inc;
            rem_n = rem_r - (AW+1)'(1);
            if (rem_r == (AW+1)'(1)) begin
              state_n = FINISH;
            end else if (post_load) begin
              state_n = BUBBLE;
              cnt_n   = bub_cnt;
            end
          end
        end
        BUBBLE: begin
          op_n  = '0;
          opv_n = 1'b0;
          cnt_n = cnt_r - CW'(1);
          if (cnt_r == CW'(1))
            state_n = ISSUE;
        end
        FINISH: begin
          op_n    = '0;
          opv_n   = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Re) begin
    if (Re) begin
      state_r <= IDLE;
      pc_r    <= '0;
      op_r    <= '0;
      opv_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= '0;
      rem_r   <= '0;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      op_r    <= op_n;
      opv_r   <= opv_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      cnt_r   <= cnt_n;
      rem_r   <= rem_n;
    end
  end

  // A registered Done stays pending across a stall and shows once Stall drops
  assign Done    = done_r & ~Stall;
  assign Opcode  = op_r;
  assign OpValid = opv_r;
  assign PC      = pc_r;
  assign Busy    = busy_r;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Directed bench for instr_issue_sequencer; expected streams follow HAZARD_CHECK_EN.
module tb_instr_issue_sequencer;

  localparam int AW = 4;

  logic          Clk, Re, WrEn, Start, Stall;
  logic [AW-1:0] WrAddr;
  logic [31:0]   WrData;
  logic [AW:0]   Length;
  logic [31:0]   Opcode;
  logic          OpValid;
  logic [AW-1:0] PC;
  logic          Busy, Done;

  int total = 0;
  int bad   = 0;

  logic [31:0] prog [5];
  logic [31:0] exp_q [$];
  int          first_bubble;

  instr_issue_sequencer #(
    .DEPTH   (16),
    .IW      (32),
    .LW_GAP  (2),
    .ALU_GAP (0)
  ) dut (
    .Clk     (Clk),
    .Re      (Re),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .Start   (Start),
    .Length  (Length),
    .Stall   (Stall),
    .Opcode  (Opcode),
    .OpValid (OpValid),
    .PC      (PC),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_prog(input int stall_at, input bit poke);
    Length = 5'd5;
    Start  = 1'b1;
    tick;
    Start = 1'b0;
    chk("busy_on", Busy, 1);
    chk("first_lat_opv", OpValid, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (poke && i == 1) begin
        WrEn   = 1'b1;
        WrAddr = '0;
        WrData = 32'hFFFF_FFFF;
      end
      tick;
      WrEn = 1'b0;
      chk($sformatf("op%0d", i), Opcode, exp_q[i]);
      chk($sformatf("opv%0d", i), OpValid, (exp_q[i] != 32'h0));
      if (i == stall_at) begin
        Stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick;
          chk("stall_op", Opcode, 0);
          chk("stall_opv", OpValid, 0);
          chk("stall_done", Done, 0);
        end
        Stall = 1'b0;
      end
    end
    tick;
    chk("done", Done, 1);
    chk("busy_off", Busy, 0);
    chk("done_opv", OpValid, 0);
    chk("done_op", Opcode, 0);
    chk("pc_end", PC, 5);
    Stall = 1'b1;
    #1 chk("done_masked", Done, 0);
    tick;
    chk("done_still_masked", Done, 0);
    Stall = 1'b0;
    #1 chk("done_deferred", Done, 1);
    tick;
    chk("done_clear", Done, 0);
  endtask

  initial begin
    prog[0] = 32'h8C0A_0008;
    prog[1] = 32'h8C0C_0010;
    prog[2] = 32'h014C_7020;
    prog[3] = 32'hAC0E_000E;
    prog[4] = 32'h8C10_000E;
`ifdef HAZARD_CHECK_EN
    exp_q = '{32'h8C0A_0008, 32'h8C0C_0010, 32'h0, 32'h0,
              32'h014C_7020, 32'hAC0E_000E, 32'h8C10_000E};
    first_bubble = 2;
`else
    exp_q = '{32'h8C0A_0008, 32'h0, 32'h0, 32'h8C0C_0010, 32'h0, 32'h0,
              32'h014C_7020, 32'hAC0E_000E, 32'h8C10_000E};
    first_bubble = 1;
`endif

    Re = 1'b0; WrEn = 1'b0; Start = 1'b0; Stall = 1'b0;
    WrAddr = '0; WrData = '0; Length = '0;
    #2 Re = 1'b1;
    #1;
    chk("rst_op", Opcode, 0);
    chk("rst_opv", OpValid, 0);
    chk("rst_pc", PC, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    tick;
    tick;
    Re = 1'b0;

    for (int i = 0; i < 5; i++) begin
      WrEn   = 1'b1;
      WrAddr = AW'(i);
      WrData = prog[i];
      tick;
    end
    WrEn = 1'b0;
    chk("idle_opv", OpValid, 0);

    run_prog(-1, 1'b0);
    run_prog(first_bubble, 1'b0);

    Length = '0;
    Start  = 1'b1;
    tick;
    Start = 1'b0;
    chk("len0_done_early", Done, 0);
    chk("len0_busy_a", Busy, 0);
    chk("len0_opv_a", OpValid, 0);
    tick;
    chk("len0_done", Done, 1);
    chk("len0_busy_b", Busy, 0);
    chk("len0_opv_b", OpValid, 0);
    tick;
    chk("len0_done_clear", Done, 0);

    Length = 5'd5;
    Start  = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    tick;
    chk("pre_rst_op", Opcode, exp_q[1]);
    Re = 1'b1;
    #1;
    chk("midrst_op", Opcode, 0);
    chk("midrst_opv", OpValid, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_pc", PC, 0);
    #1 Re = 1'b0;
    tick;
    chk("post_rst_opv", OpValid, 0);

    run_prog(-1, 1'b1);
    run_prog(-1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
